fetch_stage: RTL and testbench

// - Instruction-fetch front end: PC register, instruction-memory request/ack master, IF/ID register.
// - Consumes the hazard controls (stall_F, stall_D, flush_D, pcSource_E) and the EX redirect target.
// - Feeds the decode stage and tolerates variable imem latency with one request outstanding.

---
 rtl/riscv_pkg.sv | 21 ++
 rtl/if_id_reg.sv | 77 +++++++
 rtl/fetch_stage.sv | 150 +++++++++++++++
 tb/tb_fetch_stage.sv | 327 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
//==============================================================================
// Module : riscv_pkg
// Shared widths, the NOP encoding and the fetch FSM state type.
// Rev    : 1.0
//==============================================================================
`default_nettype none

package riscv_pkg;

    localparam int          XLEN      = 32;
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        DROP  = 2'd1,
        HOLD  = 2'd2
    } fetch_state_t;

endpackage

`default_nettype wire

// File: rtl/if_id_reg.sv
//==============================================================================
// Module : if_id_reg
// IF/ID pipeline register with flush > stall > load > bubble priority.
// Rev    : 1.0
//==============================================================================
`default_nettype none

module if_id_reg
    import riscv_pkg::*;
#(
    parameter int XLEN = riscv_pkg::XLEN
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            flush,
    input  logic            stall,
    input  logic            load,
    input  logic [XLEN-1:0] instr_in,
    input  logic [XLEN-1:0] pc_in,
    input  logic [XLEN-1:0] pc_plus4_in,
    output logic [XLEN-1:0] instr_out,
    output logic [XLEN-1:0] pc_out,
    output logic [XLEN-1:0] pc_plus4_out,
    output logic            valid_out
);

    localparam logic [XLEN-1:0] NOP = XLEN'(NOP_INSTR);

    logic [XLEN-1:0] instr_q, instr_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic [XLEN-1:0] pc_plus4_q, pc_plus4_d;
    logic            valid_q, valid_d;

    // Bubbles leave the PC fields untouched; only valid/instr are meaningful.
    always_comb begin
        instr_d    = instr_q;
        pc_d       = pc_q;
        pc_plus4_d = pc_plus4_q;
        valid_d    = valid_q;
        if (flush) begin
            valid_d = 1'b0;
            instr_d = NOP;
        end else if (!stall) begin
            if (load) begin
                instr_d    = instr_in;
                pc_d       = pc_in;
                pc_plus4_d = pc_plus4_in;
                valid_d    = 1'b1;
            end else begin
                valid_d = 1'b0;
                instr_d = NOP;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            instr_q    <= NOP;
            pc_q       <= '0;
            pc_plus4_q <= '0;
            valid_q    <= 1'b0;
        end else begin
            instr_q    <= instr_d;
            pc_q       <= pc_d;
            pc_plus4_q <= pc_plus4_d;
            valid_q    <= valid_d;
        end
    end

    assign instr_out    = instr_q;
    assign pc_out       = pc_q;
    assign pc_plus4_out = pc_plus4_q;
    assign valid_out    = valid_q;

endmodule

`default_nettype wire

// File: rtl/fetch_stage.sv
//==============================================================================
// Module : fetch_stage
// PC, single-outstanding imem request master and IF/ID register.
// Rev    : 1.0
//==============================================================================
`default_nettype none

module fetch_stage
    import riscv_pkg::*;
#(
    parameter int              XLEN     = riscv_pkg::XLEN,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            stall_F,
    input  logic            stall_D,
    input  logic            flush_D,
    input  logic            pcSource_E,
    input  logic [XLEN-1:0] jump_target_E,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_ack,
    input  logic [XLEN-1:0] imem_rdata,
    output logic [XLEN-1:0] instr_D,
    output logic [XLEN-1:0] pc_D,
    output logic [XLEN-1:0] pc_plus4_D,
    output logic            valid_D,
    output logic            fetch_wait
);

    localparam logic [XLEN-1:0] PC_STEP = XLEN'(4);

    fetch_state_t    state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic [XLEN-1:0] redirect_q, redirect_d;
    logic [XLEN-1:0] buf_instr_q, buf_instr_d;
    logic [XLEN-1:0] buf_pc_q, buf_pc_d;
    logic            buf_valid_q, buf_valid_d;

    logic            hold;
    logic            ifid_load;
    logic [XLEN-1:0] ifid_instr;
    logic [XLEN-1:0] ifid_pc;

    assign hold = stall_F | stall_D;

    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        redirect_d  = redirect_q;
        buf_instr_d = buf_instr_q;
        buf_pc_d    = buf_pc_q;
        buf_valid_d = buf_valid_q;
        ifid_load   = 1'b0;
        ifid_instr  = imem_rdata;
        ifid_pc     = pc_q;

        case (state_q)
            FETCH: begin
                if (imem_ack) begin
                    if (pcSource_E) begin
                        pc_d = jump_target_E;
                    end else begin
                        pc_d = pc_q + PC_STEP;
                        if (hold) begin
                            buf_instr_d = imem_rdata;
                            buf_pc_d    = pc_q;
                            buf_valid_d = 1'b1;
                            state_d     = HOLD;
                        end else begin
                            ifid_load = 1'b1;
                        end
                    end
                end else if (pcSource_E) begin
                    // Address must stay stable until the ack, so park the target.
                    redirect_d = jump_target_E;
                    state_d    = DROP;
                end
            end
            DROP: begin
                if (pcSource_E) begin
                    redirect_d = jump_target_E;
                end
                if (imem_ack) begin
                    pc_d    = pcSource_E ? jump_target_E : redirect_q;
                    state_d = FETCH;
                end
            end
            HOLD: begin
                if (pcSource_E) begin
                    buf_valid_d = 1'b0;
                    pc_d        = jump_target_E;
                    state_d     = FETCH;
                end else if (!hold) begin
                    ifid_load   = buf_valid_q;
                    ifid_instr  = buf_instr_q;
                    ifid_pc     = buf_pc_q;
                    buf_valid_d = 1'b0;
                    state_d     = FETCH;
                end
            end
            default: begin
                state_d = FETCH;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= FETCH;
            pc_q        <= RESET_PC;
            redirect_q  <= '0;
            buf_instr_q <= '0;
            buf_pc_q    <= '0;
            buf_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            redirect_q  <= redirect_d;
            buf_instr_q <= buf_instr_d;
            buf_pc_q    <= buf_pc_d;
            buf_valid_q <= buf_valid_d;
        end
    end

    assign imem_req   = (state_q != HOLD);
    assign imem_addr  = pc_q;
    assign fetch_wait = imem_req & ~imem_ack;

    if_id_reg #(
        .XLEN (XLEN)
    ) u_if_id_reg (
        .clk          (clk),
        .rst_n        (rst_n),
        .flush        (flush_D),
        .stall        (stall_D),
        .load         (ifid_load),
        .instr_in     (ifid_instr),
        .pc_in        (ifid_pc),
        .pc_plus4_in  (ifid_pc + PC_STEP),
        .instr_out    (instr_D),
        .pc_out       (pc_D),
        .pc_plus4_out (pc_plus4_D),
        .valid_out    (valid_D)
    );

endmodule

`default_nettype wire

// File: tb/tb_fetch_stage.sv
//==============================================================================
// Module : tb_fetch_stage
// Directed scenarios plus randomized hazards checked against a program-order stream model.
// Rev    : 1.0
//==============================================================================
`default_nettype none

module tb_fetch_stage;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam logic [31:0] NOP      = 32'h0000_0013;

    logic        clk           = 1'b0;
    logic        rst_n         = 1'b0;
    logic        stall_F       = 1'b0;
    logic        stall_D       = 1'b0;
    logic        flush_D       = 1'b0;
    logic        pcSource_E    = 1'b0;
    logic [31:0] jump_target_E = '0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack      = 1'b0;
    logic [31:0] imem_rdata    = '0;
    logic [31:0] instr_D;
    logic [31:0] pc_D;
    logic [31:0] pc_plus4_D;
    logic        valid_D;
    logic        fetch_wait;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    fetch_stage #(
        .XLEN     (32),
        .RESET_PC (RESET_PC)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .stall_F       (stall_F),
        .stall_D       (stall_D),
        .flush_D       (flush_D),
        .pcSource_E    (pcSource_E),
        .jump_target_E (jump_target_E),
        .imem_req      (imem_req),
        .imem_addr     (imem_addr),
        .imem_ack      (imem_ack),
        .imem_rdata    (imem_rdata),
        .instr_D       (instr_D),
        .pc_D          (pc_D),
        .pc_plus4_D    (pc_plus4_D),
        .valid_D       (valid_D),
        .fetch_wait    (fetch_wait)
    );

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Instruction memory: fixed or random latency, optional address blocking.
    int          fixed_lat  = 0;
    logic        block_en   = 1'b0;
    logic [31:0] block_addr = '0;
    int          lat_cnt    = -1;

    always begin
        @(posedge clk);
        #1;
        imem_ack = 1'b0;
        if (!rst_n) begin
            lat_cnt = -1;
        end else if (imem_req && !(block_en && imem_addr == block_addr)) begin
            if (lat_cnt < 0)
                lat_cnt = (fixed_lat < 0) ? int'($urandom_range(0, 3)) : fixed_lat;
            if (lat_cnt == 0) begin
                imem_ack   = 1'b1;
                imem_rdata = mem_word(imem_addr);
                lat_cnt    = -1;
            end else begin
                lat_cnt--;
            end
        end
    end

    // Scoreboard: hazards applied at each edge are queued, the monitor pops and judges.
    typedef struct {
        logic        stall_d;
        logic        flush_d;
        logic        redir;
        logic [31:0] target;
    } hz_t;

    hz_t         hz_q[$];
    hz_t         mon_h;
    bit          mon_en     = 1'b0;
    logic [31:0] exp_pc     = RESET_PC;
    int          deliveries = 0;
    logic        prev_wait  = 1'b0;
    logic [31:0] prev_addr  = '0;

    always @(posedge clk) begin
        if (mon_en && rst_n)
            hz_q.push_back('{stall_D, flush_D, pcSource_E, jump_target_E});
    end

    always @(negedge clk) begin
        if (mon_en && hz_q.size() > 0) begin
            mon_h = hz_q.pop_front();
            if (mon_h.flush_d) begin
                check("flush_valid", {31'b0, valid_D}, 32'd0);
                check("flush_nop", instr_D, NOP);
            end else if (!mon_h.stall_d && valid_D) begin
                check("stream_pc", pc_D, exp_pc);
                check("stream_instr", instr_D, mem_word(exp_pc));
                check("stream_pc4", pc_plus4_D, exp_pc + 32'd4);
                exp_pc = exp_pc + 32'd4;
                deliveries++;
            end
            if (mon_h.redir)
                exp_pc = mon_h.target;
            if (prev_wait) begin
                check("req_held", {31'b0, imem_req}, 32'd1);
                check("addr_stable", imem_addr, prev_addr);
            end
        end
        prev_wait = mon_en && imem_req && !imem_ack;
        prev_addr = imem_addr;
    end

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    logic        prev_ack;
    logic [31:0] prev_a;
    int          pulses;
    bit          seen;

    initial begin
        // Reset state, then back-to-back fetch with same-cycle ack.
        fixed_lat = 0;
        repeat (2) @(negedge clk);
        check("rst_valid", {31'b0, valid_D}, 32'd0);
        check("rst_instr", instr_D, NOP);
        check("rst_pc_d", pc_D, 32'd0);
        check("rst_pc4_d", pc_plus4_D, 32'd0);
        check("rst_addr", imem_addr, RESET_PC);
        rst_n = 1'b1;
        #1;
        check("first_req", {31'b0, imem_req}, 32'd1);
        @(negedge clk);
        check("cycle1_valid", {31'b0, valid_D}, 32'd0);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("seq_valid", {31'b0, valid_D}, 32'd1);
            check("seq_pc", pc_D, 32'(4 * i));
            check("seq_instr", instr_D, mem_word(32'(4 * i)));
        end

        // Three-cycle ack latency.
        fixed_lat = 2;
        prev_ack  = imem_ack;
        prev_a    = imem_addr;
        pulses    = 0;
        for (int i = 0; i < 9; i++) begin
            @(negedge clk);
            check("lat_req", {31'b0, imem_req}, 32'd1);
            check("lat_wait", {31'b0, fetch_wait}, {31'b0, !imem_ack});
            check("lat_valid", {31'b0, valid_D}, {31'b0, prev_ack});
            check("lat_addr", imem_addr, prev_ack ? prev_a + 32'd4 : prev_a);
            if (valid_D) pulses++;
            prev_ack = imem_ack;
            prev_a   = imem_addr;
        end
        check("lat_pulses", 32'(pulses), 32'd3);

        // stall_D over the ack at 0x10.
        fixed_lat = 0;
        do_reset();
        repeat (5) @(posedge clk);
        #1;
        stall_D = 1'b1;
        @(negedge clk);
        check("stl_pc_pre", pc_D, 32'h0C);
        check("stl_addr", imem_addr, 32'h10);
        @(negedge clk);
        check("stl_pc_h1", pc_D, 32'h0C);
        check("stl_valid_h1", {31'b0, valid_D}, 32'd1);
        check("stl_req_h1", {31'b0, imem_req}, 32'd0);
        @(negedge clk);
        check("stl_pc_h2", pc_D, 32'h0C);
        check("stl_req_h2", {31'b0, imem_req}, 32'd0);
        stall_D = 1'b0;
        @(negedge clk);
        check("stl_pc_buf", pc_D, 32'h10);
        check("stl_instr_buf", instr_D, mem_word(32'h10));
        @(negedge clk);
        check("stl_pc_next", pc_D, 32'h14);

        // Redirect while a request to 0x20 is outstanding.
        block_addr = 32'h20;
        block_en   = 1'b1;
        do_reset();
        seen = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(negedge clk);
            seen = (imem_addr == 32'h20) && fetch_wait;
        end
        check("drop_reach", {31'b0, seen}, 32'd1);
        pcSource_E    = 1'b1;
        flush_D       = 1'b1;
        jump_target_E = 32'h100;
        @(negedge clk);
        pcSource_E = 1'b0;
        flush_D    = 1'b0;
        check("drop_addr", imem_addr, 32'h20);
        check("drop_wait", {31'b0, fetch_wait}, 32'd1);
        check("drop_flush", {31'b0, valid_D}, 32'd0);
        block_en = 1'b0;
        @(negedge clk);
        check("drop_addr_ack", imem_addr, 32'h20);
        @(negedge clk);
        check("drop_new_addr", imem_addr, 32'h100);
        seen = 1'b0;
        for (int i = 0; i < 6 && !seen; i++) begin
            if (valid_D) seen = 1'b1;
            else @(negedge clk);
        end
        check("drop_deliver", {31'b0, seen}, 32'd1);
        check("drop_pc", pc_D, 32'h100);
        check("drop_instr", instr_D, mem_word(32'h100));

        // flush_D together with stall_D.
        stall_D = 1'b1;
        flush_D = 1'b1;
        @(negedge clk);
        check("fs_valid", {31'b0, valid_D}, 32'd0);
        check("fs_instr", instr_D, NOP);
        stall_D = 1'b0;
        flush_D = 1'b0;

        // Asynchronous reset while in DROP.
        block_addr = 32'h140;
        block_en   = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 60 && !seen; i++) begin
            @(negedge clk);
            seen = (imem_addr == 32'h140) && fetch_wait;
        end
        check("rd_reach", {31'b0, seen}, 32'd1);
        pcSource_E    = 1'b1;
        jump_target_E = 32'h200;
        @(negedge clk);
        pcSource_E = 1'b0;
        check("rd_wait", {31'b0, fetch_wait}, 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("rd_valid", {31'b0, valid_D}, 32'd0);
        check("rd_instr", instr_D, NOP);
        check("rd_pc_d", pc_D, 32'd0);
        check("rd_pc4_d", pc_plus4_D, 32'd0);
        check("rd_addr", imem_addr, RESET_PC);
        block_en = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("rd_addr_rel", imem_addr, RESET_PC);
        check("rd_req_rel", {31'b0, imem_req}, 32'd1);

        // Randomized hazards and latency against the stream model.
        fixed_lat = -1;
        @(negedge clk);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        hz_q.delete();
        exp_pc     = RESET_PC;
        deliveries = 0;
        rst_n      = 1'b1;
        mon_en     = 1'b1;
        repeat (3000) begin
            @(posedge clk);
            #1;
            stall_F    = ($urandom_range(0, 4) == 0);
            stall_D    = ($urandom_range(0, 4) == 0);
            pcSource_E = ($urandom_range(0, 11) == 0);
            flush_D    = pcSource_E;
            if ($urandom_range(0, 3) == 0)
                jump_target_E = 32'hFFFF_FFF0 | ($urandom & 32'h0000_000C);
            else
                jump_target_E = $urandom & 32'hFFFF_FFFC;
        end
        @(posedge clk);
        #1;
        stall_F    = 1'b0;
        stall_D    = 1'b0;
        pcSource_E = 1'b0;
        flush_D    = 1'b0;
        repeat (2) @(negedge clk);
        mon_en = 1'b0;
        check("rand_deliveries", {31'b0, deliveries >= 300}, 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
